// File: rtl/adc_bcd_conv.sv
// Averages 2^AVG_LOG2 unsigned ADC codes and converts the mean to four packed BCD digits with serial double-dabble.
// Result appears IN_W+1 edges after the final accepted sample; in_ready drops for the whole conversion and in_valid is ignored meanwhile.
module adc_bcd_conv #(
    parameter int IN_W     = 12,
    parameter int AVG_LOG2 = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    output logic            in_ready,
    output logic [15:0]     bcd_out,
    output logic            bcd_valid,
    output logic            busy
);

    localparam int SUM_W = IN_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [3:0]       LAST_IT  = 4'(IN_W - 1);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        CONV  = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic [IN_W-1:0]  r_bin;
    logic [15:0]      r_bcd;
    logic [3:0]       r_iter;
    logic [15:0]      r_bcd_out;
    logic             r_bcd_valid;

    logic             w_accept;
    logic             w_last;
    logic [SUM_W-1:0] w_sum_next;
    logic [IN_W-1:0]  w_avg;
    logic [15:0]      w_bcd_adj;
    logic [15:0]      w_bcd_shift;

    assign in_ready   = (r_state == ACCUM);
    assign busy       = (r_state != ACCUM);
    assign bcd_out    = r_bcd_out;
    assign bcd_valid  = r_bcd_valid;

    assign w_accept   = in_valid && (r_state == ACCUM);
    assign w_last     = (r_cnt == LAST_CNT);
    assign w_sum_next = r_sum + SUM_W'(in_data);
    // Upper IN_W bits of the running sum are the floor of the mean.
    assign w_avg      = w_sum_next[SUM_W-1:AVG_LOG2];

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_bcd_shift = {w_bcd_adj[14:0], r_bin[IN_W-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM:   if (w_accept && w_last) w_state_next = CONV;
            CONV:    if (r_iter == LAST_IT)  w_state_next = DONE;
            DONE:    w_state_next = ACCUM;
            default: w_state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum       <= '0;
            r_cnt       <= '0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_iter      <= '0;
            r_bcd_out   <= '0;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_bin  <= w_avg;
                            r_bcd  <= '0;
                            r_iter <= '0;
                        end else begin
                            r_sum <= w_sum_next;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                CONV: begin
                    r_bcd  <= w_bcd_shift;
                    r_bin  <= r_bin << 1;
                    r_iter <= r_iter + 4'd1;
                end
                DONE: begin
                    // Only the finished work register ever reaches the display.
                    r_bcd_out   <= r_bcd;
                    r_bcd_valid <= 1'b1;
                    r_sum       <= '0;
                    r_cnt       <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_bcd_conv.sv
// Directed bench: u_dut0 runs without averaging, u_dut1 with default 16-sample averaging.
module tb_adc_bcd_conv;

    logic        clk = 1'b0;
    logic        rst0, v0, rdy0, bv0, busy0;
    logic        rst1, v1, rdy1, bv1, busy1;
    logic [11:0] d0, d1;
    logic [15:0] bcd0, bcd1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    adc_bcd_conv #(.IN_W(12), .AVG_LOG2(0)) u_dut0 (
        .clk(clk), .rst(rst0), .in_valid(v0), .in_data(d0), .in_ready(rdy0),
        .bcd_out(bcd0), .bcd_valid(bv0), .busy(busy0)
    );

    adc_bcd_conv #(.IN_W(12), .AVG_LOG2(4)) u_dut1 (
        .clk(clk), .rst(rst1), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
        .bcd_out(bcd1), .bcd_valid(bv1), .busy(busy1)
    );

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [11:0] d);
        v0 = 1'b1;
        d0 = d;
        for (int i = 0; i < 64; i++) begin
            if (rdy0) begin
                tick();
                v0 = 1'b0;
                return;
            end
            tick();
        end
        v0 = 1'b0;
        checks++;
        errors++;
        $display("FAIL send0_timeout ready never rose, required ready within 64 cycles");
    endtask

    task automatic send1(input logic [11:0] d);
        v1 = 1'b1;
        d1 = d;
        for (int i = 0; i < 64; i++) begin
            if (rdy1) begin
                tick();
                v1 = 1'b0;
                return;
            end
            tick();
        end
        v1 = 1'b0;
        checks++;
        errors++;
        $display("FAIL send1_timeout ready never rose, required ready within 64 cycles");
    endtask

    task automatic wait_v0(output logic got, output int cyc, output logic [15:0] val);
        got = 1'b0; cyc = 0; val = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cyc++;
            if (bv0) begin
                got = 1'b1; val = bcd0;
                return;
            end
        end
    endtask

    task automatic wait_v1(output logic got, output int cyc, output logic [15:0] val);
        got = 1'b0; cyc = 0; val = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cyc++;
            if (bv1) begin
                got = 1'b1; val = bcd1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        tick(); tick();
        rst0 = 1'b0; rst1 = 1'b0;
        checks++;
        if ({rdy0, busy0, bv0, bcd0} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset0 rdy/busy/valid/bcd=%b%b%b/%h required 100/0000", rdy0, busy0, bv0, bcd0);
        end
        checks++;
        if ({rdy1, busy1, bv1, bcd1} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset1 rdy/busy/valid/bcd=%b%b%b/%h required 100/0000", rdy1, busy1, bv1, bcd1);
        end
    endtask

    task automatic test_single();
        logic got; int cyc; logic [15:0] val;
        send0(12'd4095);
        checks++;
        if ({rdy0, busy0} !== 2'b01) begin
            errors++;
            $display("FAIL single_busy rdy/busy=%b%b required 01", rdy0, busy0);
        end
        wait_v0(got, cyc, val);
        checks++;
        if (!got || cyc != 13) begin
            errors++;
            $display("FAIL single_latency got=%b cycles=%0d required 1/13", got, cyc);
        end
        checks++;
        if (val !== 16'h4095) begin
            errors++;
            $display("FAIL single_value bcd=%h required 4095", val);
        end
        tick();
        checks++;
        if ({bv0, bcd0} !== {1'b0, 16'h4095}) begin
            errors++;
            $display("FAIL single_pulse_hold valid/bcd=%b/%h required 0/4095", bv0, bcd0);
        end
    endtask

    task automatic test_back_to_back();
        logic got; int cyc; logic [15:0] val; int pulses;
        send0(12'd0);
        wait_v0(got, cyc, val);
        checks++;
        if (!got || val !== 16'h0000) begin
            errors++;
            $display("FAIL zero_value got=%b bcd=%h required 1/0000", got, val);
        end
        v0 = 1'b1; d0 = 12'd1234;
        tick();
        d0 = 12'd567;
        wait_v0(got, cyc, val);
        checks++;
        if (!got || cyc != 13 || val !== 16'h1234) begin
            errors++;
            $display("FAIL b2b_first got=%b cycles=%0d bcd=%h required 1/13/1234", got, cyc, val);
        end
        wait_v0(got, cyc, val);
        v0 = 1'b0;
        checks++;
        if (!got || cyc != 14 || val !== 16'h0567) begin
            errors++;
            $display("FAIL b2b_second got=%b spacing=%0d bcd=%h required 1/14/0567", got, cyc, val);
        end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bv0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL b2b_extra pulses=%0d required 0", pulses);
        end
    endtask

    task automatic test_rst_priority();
        int pulses;
        v0 = 1'b1; d0 = 12'd777; rst0 = 1'b1;
        tick();
        rst0 = 1'b0; v0 = 1'b0;
        checks++;
        if ({rdy0, busy0} !== 2'b10) begin
            errors++;
            $display("FAIL rst_priority rdy/busy=%b%b required 10", rdy0, busy0);
        end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bv0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL rst_priority_pulse pulses=%0d required 0", pulses);
        end
    endtask

    task automatic test_average();
        logic got; int cyc; logic [15:0] val; int pulses;
        for (int i = 0; i < 15; i++) send1(i < 8 ? 12'd100 : 12'd101);
        checks++;
        if ({busy1, bv1} !== 2'b00) begin
            errors++;
            $display("FAIL avg_partial busy/valid=%b%b required 00", busy1, bv1);
        end
        send1(12'd101);
        wait_v1(got, cyc, val);
        checks++;
        if (!got || cyc != 13 || val !== 16'h0100) begin
            errors++;
            $display("FAIL avg_value got=%b cycles=%0d bcd=%h required 1/13/0100", got, cyc, val);
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bv1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL avg_extra pulses=%0d required 0", pulses);
        end
    endtask

    task automatic test_held();
        int acc; int pulses; int bad_rdy;
        acc = 0; pulses = 0; bad_rdy = 0;
        v1 = 1'b1; d1 = 12'd999;
        for (int i = 0; i < 200 && pulses < 3; i++) begin
            if (rdy1 === busy1) bad_rdy++;
            if (rdy1) acc++;
            tick();
            if (bv1) begin
                checks++;
                if (acc != 16 || bcd1 !== 16'h0999) begin
                    errors++;
                    $display("FAIL held_conv accepted=%0d bcd=%h required 16/0999", acc, bcd1);
                end
                acc = 0;
                pulses++;
            end
        end
        v1 = 1'b0;
        checks++;
        if (pulses != 3 || bad_rdy != 0) begin
            errors++;
            $display("FAIL held_summary pulses=%0d ready_busy_clash=%0d required 3/0", pulses, bad_rdy);
        end
    endtask

    task automatic test_abort();
        logic got; int cyc; logic [15:0] val; int pulses;
        for (int i = 0; i < 16; i++) send1(12'd1234);
        for (int i = 0; i < 5; i++) tick();
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        checks++;
        if ({bcd1, busy1, rdy1, bv1} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL abort_state bcd=%h busy=%b rdy=%b valid=%b required 0000/0/1/0", bcd1, busy1, rdy1, bv1);
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bv1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_pulse pulses=%0d required 0", pulses);
        end
        for (int i = 0; i < 16; i++) send1(12'd2048);
        wait_v1(got, cyc, val);
        checks++;
        if (!got || val !== 16'h2048) begin
            errors++;
            $display("FAIL abort_recover got=%b bcd=%h required 1/2048", got, val);
        end
    endtask

    task automatic test_sweep();
        logic got; int cyc; logic [15:0] val; logic [15:0] exp;
        for (int c = 0; c < 4096; c++) begin
            send0(12'(c));
            wait_v0(got, cyc, val);
            exp = to_bcd(c);
            checks++;
            if (!got || val !== exp || val[15:12] > 4'd9 || val[11:8] > 4'd9 ||
                val[7:4] > 4'd9 || val[3:0] > 4'd9) begin
                errors++;
                $display("FAIL sweep code=%0d got=%b bcd=%h required %h", c, got, val, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_rst_priority();
        test_average();
        test_held();
        test_abort();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_bcd_conv.md
ADC_BCD_CONV -- requirements
Module: adc_bcd_conv

Interface
REQ-001 SHALL have parameter IN_W, default 12, meaning input code width; legal range 1..13, so the maximum code (2^IN_W-1) never exceeds 9999.
REQ-002 SHALL have parameter AVG_LOG2, default 4, meaning that 2^AVG_LOG2 samples are averaged per conversion; legal range 0..8.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, upstream sample valid (XADC code strobe).
REQ-006 SHALL have port in_data, input, IN_W bits, unsigned ADC code.
REQ-007 SHALL have port in_ready, output, 1 bit, block accepts a sample this cycle.
REQ-008 SHALL have port bcd_out, output, 16 bits, four packed BCD digits: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units; drives the seven-segment display stage data input directly.
REQ-009 SHALL have port bcd_valid, output, 1 bit, one-cycle pulse on each bcd_out update.
REQ-010 SHALL have port busy, output, 1 bit, high while a conversion is in progress.

Function
REQ-011 SHALL implement the states ACCUM, CONV and DONE.
REQ-012 SHALL drive in_ready = (state==ACCUM) and busy = (state!=ACCUM), both combinational from state.
REQ-013 SHALL accept a sample only on an edge where in_valid && in_ready; when in_ready is low, in_valid SHALL be ignored, with no queuing and no count change.
REQ-014 SHALL, in ACCUM, add each accepted sample to a sum register of width IN_W+AVG_LOG2 that cannot overflow, and increment a sample counter.
REQ-015 SHALL, on the edge accepting sample number 2^AVG_LOG2, load (sum+in_data)>>AVG_LOG2 (floor) into the binary shift register, clear the BCD work register, and enter CONV.
REQ-016 SHALL, in CONV, perform exactly IN_W double-dabble iterations, one per edge: add 3 to every BCD work digit >=5, then shift {bcd,bin} left by 1.
REQ-017 SHALL, on the IN_W-th CONV edge, enter DONE.
REQ-018 SHALL, on the DONE edge, register the work register to bcd_out, set bcd_valid=1 for exactly one cycle, clear sum and counter, and return to ACCUM.
REQ-019 SHALL have a latency such that bcd_valid is high in the cycle following the (IN_W+1)-th rising edge after the edge accepting the final sample; minimum spacing between bcd_valid pulses = IN_W+2 cycles when AVG_LOG2=0.
REQ-020 SHALL hold bcd_out stable between updates; no intermediate BCD values SHALL ever appear on bcd_out.
REQ-021 SHALL, with AVG_LOG2=0, convert every accepted sample with no averaging.
REQ-022 SHALL produce only digits 0..9 in bcd_out for all legal inputs.
REQ-023 SHALL use no combinational path from in_data to bcd_out.

Reset
REQ-024 SHALL, with rst high at an edge, set state=ACCUM, sum=0, counter=0, work registers=0, bcd_out=16'h0000 and bcd_valid=0; in_ready=1 and busy=0 after that edge.
REQ-025 SHALL treat rst during CONV or DONE as an abort: the partial result is discarded and no bcd_valid pulse occurs.
REQ-026 SHALL let rst take priority over a simultaneous sample acceptance; that sample is dropped.

Verification
REQ-027 SHALL pass this scenario: AVG_LOG2=0, single sample 4095 -> bcd_out=16'h4095, bcd_valid high exactly one cycle, 13 edges after acceptance.
REQ-028 SHALL pass this scenario: AVG_LOG2=0, sample 0 -> bcd_out=16'h0000 with bcd_valid pulse; samples 1234 then 567 back-to-back (in_valid held high) -> pulses with 16'h1234 then 16'h0567, 14 cycles apart.
REQ-029 SHALL pass this scenario: default parameters, 8 samples of 100 then 8 of 101 (sum 1608) -> bcd_out=16'h0100, exactly one pulse.
REQ-030 SHALL pass this scenario: in_valid held high with data 999 throughout -> exactly 16 samples accepted per conversion, in_ready low during CONV/DONE, bcd_out=16'h0999 repeatedly.
REQ-031 SHALL pass this scenario: rst pulsed for one cycle mid-CONV -> bcd_out=16'h0000, busy=0, no pulse; next 16 samples of 2048 -> 16'h2048.
REQ-032 SHALL pass this scenario: sweep of all 4096 codes with AVG_LOG2=0 -> each bcd_out equals the decimal of its code, all digits <=9.
